// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: per-channel N-flop synchronizer, optional
// debounce filter, and registered single-cycle rise/fall pulses.
module input_conditioner #(
  parameter int               WIDTH           = 8,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] in_i,
  input  logic [WIDTH-1:0] debounce_en_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             any_change_o
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [CW-1:0]    r_cnt  [WIDTH];
  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_any;

  logic [WIDTH-1:0] w_sync_out;
  logic [WIDTH-1:0] w_next_level;
  logic [CW-1:0]    w_next_cnt [WIDTH];
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= RESET_VALUE;
      end
    end else begin
      r_sync[0] <= in_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  // A differing sample only wins after DEBOUNCE_CYCLES consecutive disagreements.
  always_comb begin
    w_next_level = r_level;
    for (int i = 0; i < WIDTH; i++) begin
      w_next_cnt[i] = '0;
      if (!debounce_en_i[i]) begin
        w_next_level[i] = w_sync_out[i];
      end else if (w_sync_out[i] != r_level[i]) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_next_level[i] = w_sync_out[i];
        end else begin
          w_next_cnt[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign w_rise = w_next_level & ~r_level;
  assign w_fall = ~w_next_level & r_level;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_level <= RESET_VALUE;
      r_rise  <= '0;
      r_fall  <= '0;
      r_any   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_level <= w_next_level;
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      r_any   <= |(w_rise | w_fall);
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_next_cnt[i];
      end
    end
  end

  assign level_o      = r_level;
  assign rise_o       = r_rise;
  assign fall_o       = r_fall;
  assign any_change_o = r_any;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner with WIDTH=3, N=2, D=4;
// edge numbers below count rising clock edges after the stimulus change.
module tb_input_conditioner;

  logic       clk;
  logic       rstN;
  logic [2:0] inBits;
  logic [2:0] debEn;
  logic [2:0] levelOut;
  logic [2:0] riseOut;
  logic [2:0] fallOut;
  logic       anyOut;

  int checkCount = 0;
  int errorCount = 0;

  input_conditioner #(
    .WIDTH(3),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .RESET_VALUE(3'b000)
  ) dut (
    .clk_i(clk),
    .rst_ni(rstN),
    .in_i(inBits),
    .debounce_en_i(debEn),
    .level_o(levelOut),
    .rise_o(riseOut),
    .fall_o(fallOut),
    .any_change_o(anyOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drives the raw inputs between clock edges.
  task automatic applyStimulus(input logic [2:0] inVal, input logic [2:0] enVal);
    inBits = inVal;
    debEn  = enVal;
  endtask

  // Advances to just after the next rising edge so outputs are stable.
  task automatic nextEdge(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkAll(input string tag, input logic [2:0] lvl,
                          input logic [2:0] rs, input logic [2:0] fl, input logic an);
    checkOutput({tag, "_level"}, {29'd0, levelOut}, {29'd0, lvl});
    checkOutput({tag, "_rise"},  {29'd0, riseOut},  {29'd0, rs});
    checkOutput({tag, "_fall"},  {29'd0, fallOut},  {29'd0, fl});
    checkOutput({tag, "_any"},   {31'd0, anyOut},   {31'd0, an});
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(3'b111, 3'b000);

    // Reset holds everything at zero even with inputs high.
    nextEdge(2);
    checkAll("rst_hold", 3'b000, 3'b000, 3'b000, 1'b0);

    // Bypass path: level and rise visible after edge 3.
    rstN = 1'b1;
    nextEdge(2);
    checkAll("byp_e2", 3'b000, 3'b000, 3'b000, 1'b0);
    nextEdge(1);
    checkAll("byp_e3", 3'b111, 3'b111, 3'b000, 1'b1);
    nextEdge(1);
    checkAll("byp_e4", 3'b111, 3'b000, 3'b000, 1'b0);

    applyStimulus(3'b000, 3'b000);
    nextEdge(2);
    nextEdge(1);
    checkAll("byp_fall", 3'b000, 3'b000, 3'b111, 1'b1);
    nextEdge(1);

    // Debounce latency on channel 0: nothing before edge 6.
    applyStimulus(3'b001, 3'b001);
    for (int e = 1; e <= 5; e++) begin
      nextEdge(1);
      checkOutput("dbl_early_level", {29'd0, levelOut}, 32'd0);
      checkOutput("dbl_early_rise",  {29'd0, riseOut},  32'd0);
    end
    nextEdge(1);
    checkAll("dbl_e6", 3'b001, 3'b001, 3'b000, 1'b1);
    nextEdge(1);
    checkAll("dbl_e7", 3'b001, 3'b000, 3'b000, 1'b0);

    applyStimulus(3'b000, 3'b001);
    nextEdge(5);
    nextEdge(1);
    checkAll("dbl_fall", 3'b000, 3'b000, 3'b001, 1'b1);
    nextEdge(2);

    // Three-cycle glitch is shorter than the window and is dropped.
    applyStimulus(3'b001, 3'b001);
    nextEdge(3);
    applyStimulus(3'b000, 3'b001);
    for (int e = 4; e <= 10; e++) begin
      nextEdge(1);
      checkOutput("gl3_level", {29'd0, levelOut}, 32'd0);
      checkOutput("gl3_any",   {31'd0, anyOut},   32'd0);
    end

    // Four-cycle pulse: rise at edge 6, fall at edge 10.
    applyStimulus(3'b001, 3'b001);
    nextEdge(4);
    applyStimulus(3'b000, 3'b001);
    nextEdge(1);
    checkAll("gl4_e5", 3'b000, 3'b000, 3'b000, 1'b0);
    nextEdge(1);
    checkAll("gl4_e6", 3'b001, 3'b001, 3'b000, 1'b1);
    nextEdge(3);
    checkAll("gl4_e9", 3'b001, 3'b000, 3'b000, 1'b0);
    nextEdge(1);
    checkAll("gl4_e10", 3'b000, 3'b000, 3'b001, 1'b1);
    nextEdge(1);
    checkAll("gl4_e11", 3'b000, 3'b000, 3'b000, 1'b0);

    // Simultaneous channels with debounce off.
    applyStimulus(3'b101, 3'b000);
    nextEdge(3);
    checkAll("sim_e3", 3'b101, 3'b101, 3'b000, 1'b1);
    applyStimulus(3'b010, 3'b000);
    nextEdge(1);
    checkAll("sim_e4", 3'b101, 3'b000, 3'b000, 1'b0);
    nextEdge(1);
    nextEdge(1);
    checkAll("sim_e6", 3'b010, 3'b010, 3'b101, 1'b1);
    nextEdge(1);
    checkAll("sim_e7", 3'b010, 3'b000, 3'b000, 1'b0);
    applyStimulus(3'b000, 3'b000);
    nextEdge(4);
    checkAll("sim_clear", 3'b000, 3'b000, 3'b000, 1'b0);

    // Reset mid-count on channel 1 aborts the count without a pulse.
    applyStimulus(3'b010, 3'b010);
    nextEdge(4);
    checkOutput("rmc_e4_level", {29'd0, levelOut}, 32'd0);
    rstN = 1'b0;
    #1;
    checkAll("rmc_async", 3'b000, 3'b000, 3'b000, 1'b0);
    nextEdge(2);
    checkAll("rmc_hold", 3'b000, 3'b000, 3'b000, 1'b0);
    rstN = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      nextEdge(1);
      checkOutput("rmc_early_level", {29'd0, levelOut}, 32'd0);
      checkOutput("rmc_early_rise",  {29'd0, riseOut},  32'd0);
    end
    nextEdge(1);
    checkAll("rmc_e6", 3'b010, 3'b010, 3'b000, 1'b1);
    applyStimulus(3'b000, 3'b000);
    nextEdge(4);
    checkAll("rmc_clear", 3'b000, 3'b000, 3'b000, 1'b0);

    // Clearing the enable mid-count lets the level follow immediately.
    applyStimulus(3'b100, 3'b100);
    nextEdge(4);
    checkAll("enc_e4", 3'b000, 3'b000, 3'b000, 1'b0);
    applyStimulus(3'b100, 3'b000);
    nextEdge(1);
    checkAll("enc_e5", 3'b100, 3'b100, 3'b000, 1'b1);
    nextEdge(1);
    checkAll("enc_e6", 3'b100, 3'b000, 3'b000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
